// File: rtl/countdown_pkg.sv
// Shared types and limits for the countdown timer (mm:ss:cc, binary fields).
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic [7:0] CS_MAX  = 8'd99;
  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd99;

  // Saturating clamp so oversized presets pin to the field limit instead of wrapping.
  function automatic logic [7:0] clamp_u8(input logic [7:0] value, input logic [7:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Enable-gated, clearable prescaler; tick is high during the last count of each period.
module countdown_tick_gen #(
  parameter int TICK_PERIOD = 500000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] count_q;

  // Holding (not clearing) while disabled keeps the partial count across a pause.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Preset-and-decrement mm:ss:cc countdown with pause/resume and expiry pulse/level.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the last preset at expiry and keep running.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_PERIOD = 500000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start_stop,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic [7:0] cs,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_t     state_q, state_d;
  logic [7:0] min_q, sec_q, cs_q;
  logic [7:0] min_d, sec_d, cs_d;
  logic [7:0] dec_min, dec_sec, dec_cs;
  logic       done_q, done_d;
  logic       presc_clear;
  logic       run_en;
  logic       tick;
  logic       value_nonzero;
  logic       dec_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [7:0] reload_min_q, reload_sec_q;
`endif

  assign run_en = (state_q == RUN);

  countdown_tick_gen #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_tick_gen (
    .clk_in(qzt_clk),
    .reset (reset),
    .enable(run_en),
    .clear (presc_clear),
    .tick  (tick)
  );

  assign value_nonzero = (min_q != 8'd0) || (sec_q != 8'd0) || (cs_q != 8'd0);

  // One-centisecond decrement with borrow; a zero value simply holds.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    dec_cs  = cs_q;
    if (cs_q != 8'd0) begin
      dec_cs = cs_q - 8'd1;
    end else if (sec_q != 8'd0) begin
      dec_cs  = CS_MAX;
      dec_sec = sec_q - 8'd1;
    end else if (min_q != 8'd0) begin
      dec_cs  = CS_MAX;
      dec_sec = SEC_MAX;
      dec_min = min_q - 8'd1;
    end
  end

  assign dec_zero = (dec_min == 8'd0) && (dec_sec == 8'd0) && (dec_cs == 8'd0);

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    cs_d        = cs_q;
    done_d      = 1'b0;
    presc_clear = 1'b0;

    if (load) begin
      state_d     = IDLE;
      min_d       = clamp_u8(preset_min, MIN_MAX);
      sec_d       = clamp_u8(preset_sec, SEC_MAX);
      cs_d        = 8'd0;
      presc_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop && value_nonzero) begin
            state_d     = RUN;
            presc_clear = 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (dec_zero) begin
              done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              min_d = reload_min_q;
              sec_d = reload_sec_q;
              cs_d  = 8'd0;
`else
              state_d = EXPIRED;
              min_d   = 8'd0;
              sec_d   = 8'd0;
              cs_d    = 8'd0;
`endif
            end else begin
              min_d = dec_min;
              sec_d = dec_sec;
              cs_d  = dec_cs;
            end
          end
          // A tick landing on the pause edge still counts; expiry beats pausing.
          if (start_stop && (state_d == RUN)) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state_d = RUN;
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      min_q   <= 8'd0;
      sec_q   <= 8'd0;
      cs_q    <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      reload_min_q <= 8'd0;
      reload_sec_q <= 8'd0;
    end else if (load) begin
      reload_min_q <= clamp_u8(preset_min, MIN_MAX);
      reload_sec_q <= clamp_u8(preset_sec, SEC_MAX);
    end
  end
`endif

  assign min     = min_q;
  assign sec     = sec_q;
  assign cs      = cs_q;
  assign running = (state_q == RUN);
  assign done    = done_q;
  assign expired = (state_q == EXPIRED);

endmodule
